// File: rtl/shiftreg_seq_ctrl.sv
// Sequencer for a 74HC595-style serial shift-register chain: shifts a word out, strobes the
// latch and captures the returned bits. Build with SHIFTREG_LSB_FIRST_EN for LSB-first order.
module shiftreg_seq_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] tx_data,
  input  logic [DIV_W-1:0] div,
  input  logic             sr_din,
  output logic             sr_dout,
  output logic             sr_clk,
  output logic             sr_latch,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rx_data
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StHigh,
    StLatch
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] tx_sh_q;
  logic [WIDTH-1:0] rx_sh_q;
  logic [WIDTH-1:0] rx_data_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] phase_q;
  logic [CntW-1:0]  bit_q;
  logic             sr_dout_q;
  logic             sr_clk_q;
  logic             sr_latch_q;
  logic             busy_q;
  logic             done_q;

  logic             phase_last;
  logic             bit_last;
  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-1:0] tx_shifted;
  logic [WIDTH-1:0] rx_shifted;

  // Phase counter runs 0..div inclusive, so div = all-ones never wraps early.
  assign phase_last = (phase_q == div_q);
  assign bit_last   = (bit_q == CntW'(WIDTH - 1));

`ifdef SHIFTREG_LSB_FIRST_EN
  assign first_bit  = tx_data[0];
  assign next_bit   = tx_sh_q[1];
  assign tx_shifted = tx_sh_q >> 1;
  assign rx_shifted = {sr_din, rx_sh_q[WIDTH-1:1]};
`else
  assign first_bit  = tx_data[WIDTH-1];
  assign next_bit   = tx_sh_q[WIDTH-2];
  assign tx_shifted = tx_sh_q << 1;
  assign rx_shifted = {rx_sh_q[WIDTH-2:0], sr_din};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      div_q      <= '0;
      phase_q    <= '0;
      bit_q      <= '0;
      sr_dout_q  <= 1'b0;
      sr_clk_q   <= 1'b0;
      sr_latch_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q   <= StSetup;
            tx_sh_q   <= tx_data;
            div_q     <= div;
            phase_q   <= '0;
            bit_q     <= '0;
            sr_dout_q <= first_bit;
            busy_q    <= 1'b1;
          end
        end
        StSetup: begin
          if (phase_last) begin
            // Sample the return bit just before the rising shift edge.
            phase_q  <= '0;
            rx_sh_q  <= rx_shifted;
            sr_clk_q <= 1'b1;
            state_q  <= StHigh;
          end else begin
            phase_q <= phase_q + DIV_W'(1);
          end
        end
        StHigh: begin
          if (phase_last) begin
            phase_q  <= '0;
            sr_clk_q <= 1'b0;
            if (bit_last) begin
              sr_latch_q <= 1'b1;
              state_q    <= StLatch;
            end else begin
              bit_q     <= bit_q + CntW'(1);
              tx_sh_q   <= tx_shifted;
              sr_dout_q <= next_bit;
              state_q   <= StSetup;
            end
          end else begin
            phase_q <= phase_q + DIV_W'(1);
          end
        end
        StLatch: begin
          if (phase_last) begin
            phase_q    <= '0;
            sr_latch_q <= 1'b0;
            sr_dout_q  <= 1'b0;
            rx_data_q  <= rx_sh_q;
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= StIdle;
          end else begin
            phase_q <= phase_q + DIV_W'(1);
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign sr_dout  = sr_dout_q;
  assign sr_clk   = sr_clk_q;
  assign sr_latch = sr_latch_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign rx_data  = rx_data_q;

endmodule

// File: tb/tb_shiftreg_seq_ctrl.sv
// Scoreboard bench for shiftreg_seq_ctrl: a behavioural 8-bit chain feeds sr_din, stimulus
// pushes expected transfer results, and a monitor checks each done pulse against them.
module tb_shiftreg_seq_ctrl;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DIV_W = 8;

`ifdef SHIFTREG_LSB_FIRST_EN
  localparam bit LsbFirst = 1'b1;
`else
  localparam bit LsbFirst = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] tx_data;
  logic [DIV_W-1:0] div;
  logic             sr_din;
  logic             sr_dout;
  logic             sr_clk;
  logic             sr_latch;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] rx_data;

  shiftreg_seq_ctrl #(
    .WIDTH(WIDTH),
    .DIV_W(DIV_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .tx_data (tx_data),
    .div     (div),
    .sr_din  (sr_din),
    .sr_dout (sr_dout),
    .sr_clk  (sr_clk),
    .sr_latch(sr_latch),
    .busy    (busy),
    .done    (done),
    .rx_data (rx_data)
  );

  always #5 clk = ~clk;

  // Behavioural chain: shifts sr_dout in on each sr_clk rise, returns its MSB.
  logic [7:0] model = 8'h00;
  logic [7:0] preload = 8'h00;
  logic       load = 1'b0;
  logic       sr_clk_d = 1'b0;
  always @(posedge clk) begin
    if (load) model <= preload;
    else if (sr_clk && !sr_clk_d) model <= {model[6:0], sr_dout};
    sr_clk_d <= sr_clk;
  end
  assign sr_din = model[7];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] rx;
    logic [7:0] mdl;
    int         lat;
    int         latch;
    int         pulses;
    int         hi;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   done_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: tracks per-transfer waveform statistics and checks each done pulse.
  initial begin
    int   acc_cyc;
    int   latch_cnt;
    int   pulses;
    int   hi_run;
    int   hi_min;
    int   hi_max;
    logic prev_busy;
    logic prev_clk;
    exp_t e;
    acc_cyc = 0; latch_cnt = 0; pulses = 0; hi_run = 0; hi_min = 1000; hi_max = 0;
    prev_busy = 1'b0; prev_clk = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_busy = 1'b0;
        prev_clk  = 1'b0;
        hi_run    = 0;
      end else begin
        if (done) begin
          done_seen++;
          if (sb_q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL unexpected_done: got done=1 expected no transfer (t=%0t)", $time);
          end else begin
            e = sb_q.pop_front();
            check("rx_data", rx_data, e.rx);
            check("chain_model", model, e.mdl);
            check("done_latency", cyc - acc_cyc, e.lat);
            check("latch_cycles", latch_cnt, e.latch);
            check("clk_pulses", pulses, e.pulses);
            check("clk_high_min", hi_min, e.hi);
            check("clk_high_max", hi_max, e.hi);
            check("busy_in_done", busy, 0);
          end
        end
        if (busy && !prev_busy) begin
          acc_cyc = cyc; latch_cnt = 0; pulses = 0; hi_run = 0; hi_min = 1000; hi_max = 0;
        end
        if (sr_latch) latch_cnt++;
        if (sr_clk) hi_run++;
        else if (prev_clk) begin
          pulses++;
          if (hi_run < hi_min) hi_min = hi_run;
          if (hi_run > hi_max) hi_max = hi_run;
          hi_run = 0;
        end
        prev_busy = busy;
        prev_clk  = sr_clk;
      end
    end
  end

  task automatic issue(input logic [7:0] tx, input logic [7:0] dv, input logic [7:0] exp_rx,
                       input logic [7:0] exp_mdl);
    exp_t e;
    logic first;
    e.rx = exp_rx; e.mdl = exp_mdl; e.lat = 17 * (int'(dv) + 1);
    e.latch = int'(dv) + 1; e.pulses = 8; e.hi = int'(dv) + 1;
    first = LsbFirst ? tx[0] : tx[7];
    @(negedge clk);
    tx_data = tx; div = dv; start = 1'b1;
    sb_q.push_back(e);
    @(negedge clk);
    check("accept_busy", busy, 1);
    check("first_dout", sr_dout, first);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while (!done && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      errors++;
      checks++;
      $display("FAIL done_timeout: got no done after %0d cycles expected done", limit);
    end
  endtask

  task automatic preload_model(input logic [7:0] v);
    @(negedge clk);
    preload = v; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; tx_data = '0; div = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_sr_dout", sr_dout, 0);
    check("rst_sr_clk", sr_clk, 0);
    check("rst_sr_latch", sr_latch, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rx_data", rx_data, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_sr_clk", sr_clk, 0);

    // Basic transfer, div=0.
    preload_model(8'h3C);
    issue(8'hA5, 8'd0, 8'h3C, 8'hA5);
    wait_done(100);

    // Divider: four-cycle phases.
    issue(8'hFF, 8'd3, 8'hA5, 8'hFF);
    wait_done(200);

    // Start pulsed mid-transfer is ignored.
    issue(8'hA5, 8'd1, 8'hFF, 8'hA5);
    repeat (10) @(negedge clk);
    tx_data = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(100);
    repeat (5) @(negedge clk);
    check("no_queued_start", busy, 0);

    // Back-to-back: start held through the done cycle.
    issue(8'h5A, 8'd0, 8'hA5, 8'h5A);
    start = 1'b1;
    tx_data = 8'hC3;
    begin
      exp_t e2;
      e2.rx = 8'h5A; e2.mdl = 8'hC3; e2.lat = 17; e2.latch = 1; e2.pulses = 8; e2.hi = 1;
      sb_q.push_back(e2);
    end
    wait_done(100);
    check("b2b_busy_low_in_done", busy, 0);
    @(negedge clk);
    check("b2b_second_accept", busy, 1);
    start = 1'b0;
    wait_done(100);

    // Reset after three sr_clk pulses aborts without done.
    begin
      int   rises;
      int   n;
      int   d0;
      logic prev;
      @(negedge clk);
      tx_data = 8'hFF; div = 8'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      rises = 0; n = 0; prev = sr_clk;
      while (rises < 3 && n < 100) begin
        @(negedge clk);
        n++;
        if (sr_clk && !prev) rises++;
        prev = sr_clk;
      end
      check("rst_mid_pulses_seen", rises, 3);
      rst = 1'b1;
      d0 = done_seen;
      @(negedge clk);
      check("rst_mid_sr_clk", sr_clk, 0);
      check("rst_mid_sr_latch", sr_latch, 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_rx_data", rx_data, 0);
      rst = 1'b0;
      repeat (60) @(negedge clk);
      check("rst_mid_no_done", done_seen - d0, 0);
      check("rst_mid_idle", busy, 0);
    end

    // Bit order: LSB-first build delivers tx_data[0] first.
    preload_model(8'h3C);
    issue(8'h01, 8'd0, 8'h3C, LsbFirst ? 8'h80 : 8'h01);
    wait_done(100);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
